// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pkg
//  Description : Shared types and defaults for the RR record buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_pkg;

    localparam int unsigned RR_CTR_WIDTH   = 22;
    localparam int unsigned RR_MIN_DEFAULT = 50;
    localparam int unsigned RR_MAX_DEFAULT = 500;

    typedef enum logic [0:0] {
        WAIT_FIRST = 1'b0,
        ARMED      = 1'b1
    } rr_state_e;

    typedef struct packed {
        logic                    artefact;
        logic [RR_CTR_WIDTH-1:0] rr_period;
        logic [RR_CTR_WIDTH-1:0] rpeak_location;
    } rr_record_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : First-word-fall-through synchronous FIFO with level output.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 45,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_en,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_drop
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_level == C_DEPTH);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a write into a full FIFO is accepted then.
    assign w_pop  = i_rd_en && !o_empty;
    assign w_push = i_wr_en && (!o_full || w_pop);
    assign o_drop = i_wr_en && !w_push;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_record_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : rr_record_buffer
//  Description : Captures RR updates as range-flagged records into a FIFO
//                drained over valid/ready. Define RR_AVG_EN for running mean.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_record_buffer
    import rr_pkg::*;
#(
    parameter int unsigned CTR_WIDTH  = RR_CTR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RR_MIN     = RR_MIN_DEFAULT,
    parameter int unsigned RR_MAX     = RR_MAX_DEFAULT,
    parameter int unsigned NAVG       = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_ce,
    input  logic                          i_alg_active,
    input  logic [CTR_WIDTH-1:0]          i_rr_period,
    input  logic                          i_rr_period_updated,
    input  logic [CTR_WIDTH-1:0]          i_rpeak_location,
    output logic [2*CTR_WIDTH:0]          o_rec_data,
    output logic                          o_rec_valid,
    input  logic                          i_rec_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic [CTR_WIDTH-1:0]          o_rr_avg,
    output logic                          o_rr_avg_valid
);

    localparam logic [0:0]           ST_WAIT_FIRST = WAIT_FIRST;
    localparam logic [0:0]           ST_ARMED      = ARMED;
    localparam logic [CTR_WIDTH-1:0] C_RR_MIN      = CTR_WIDTH'(RR_MIN);
    localparam logic [CTR_WIDTH-1:0] C_RR_MAX      = CTR_WIDTH'(RR_MAX);

    logic [0:0]           r_state;
    logic                 w_capture;
    logic                 w_artefact;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_drop;
    logic                 r_overflow;

    assign w_capture  = (r_state == ST_ARMED) && i_ce && i_rr_period_updated;
    assign w_artefact = (i_rr_period < C_RR_MIN) || (i_rr_period > C_RR_MAX);

    // The first strobe after arming is dropped: its period has no preceding peak.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_WAIT_FIRST;
        end else if (i_ce) begin
            case (r_state)
                ST_WAIT_FIRST: if (i_alg_active && i_rr_period_updated) r_state <= ST_ARMED;
                ST_ARMED:      if (!i_alg_active)                       r_state <= ST_WAIT_FIRST;
                default:       r_state <= ST_WAIT_FIRST;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (2*CTR_WIDTH+1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_capture),
        .i_wr_data ({w_artefact, i_rr_period, i_rpeak_location}),
        .i_rd_en   (i_rec_ready),
        .o_rd_data (o_rec_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_fifo_level),
        .o_drop    (w_drop)
    );

    assign o_rec_valid = !w_empty;
    assign o_overflow  = r_overflow;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef RR_AVG_EN
    localparam int unsigned LA = $clog2(NAVG);
    localparam int unsigned SW = CTR_WIDTH + LA;

    logic [CTR_WIDTH-1:0] r_hist [NAVG];
    logic [LA-1:0]        r_hidx;
    logic [LA:0]          r_cnt;
    logic [SW-1:0]        r_sum;
    logic [SW-1:0]        w_sum_next;
    logic [CTR_WIDTH-1:0] r_avg;
    logic                 r_avg_valid;
    logic                 w_avg_push;

    // Dropped-on-overflow records still count: the average tracks the heart, not the FIFO.
    assign w_avg_push = w_capture && !w_artefact;
    assign w_sum_next = r_sum + SW'(i_rr_period) - SW'(r_hist[r_hidx]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hidx      <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            for (int i = 0; i < int'(NAVG); i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_avg_push) begin
            r_hist[r_hidx] <= i_rr_period;
            r_hidx         <= r_hidx + 1'b1;
            r_sum          <= w_sum_next;
            r_avg          <= w_sum_next[SW-1:LA];
            if (r_cnt != (LA+1)'(NAVG)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt == (LA+1)'(NAVG-1)) begin
                r_avg_valid <= 1'b1;
            end
        end
    end

    assign o_rr_avg       = r_avg;
    assign o_rr_avg_valid = r_avg_valid;
`else
    assign o_rr_avg       = '0;
    assign o_rr_avg_valid = 1'b0;
`endif

    logic w_unused;
    assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_rr_record_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_record_buffer
//  Description : Directed self-checking bench for rr_record_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_record_buffer;
    import rr_pkg::*;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_ce = 1'b1;
    logic          i_alg_active = 1'b0;
    logic [21:0]   i_rr_period = '0;
    logic          i_rr_period_updated = 1'b0;
    logic [21:0]   i_rpeak_location = '0;
    logic [44:0]   o_rec_data;
    logic          o_rec_valid;
    logic          i_rec_ready = 1'b0;
    logic [3:0]    o_fifo_level;
    logic          o_overflow;
    logic [21:0]   o_rr_avg;
    logic          o_rr_avg_valid;

    int total = 0;
    int bad   = 0;
    rr_record_t exp;

    always #5 clk = ~clk;

    rr_record_buffer dut (
        .i_clk               (clk),
        .i_rst               (i_rst),
        .i_ce                (i_ce),
        .i_alg_active        (i_alg_active),
        .i_rr_period         (i_rr_period),
        .i_rr_period_updated (i_rr_period_updated),
        .i_rpeak_location    (i_rpeak_location),
        .o_rec_data          (o_rec_data),
        .o_rec_valid         (o_rec_valid),
        .i_rec_ready         (i_rec_ready),
        .o_fifo_level        (o_fifo_level),
        .o_overflow          (o_overflow),
        .o_rr_avg            (o_rr_avg),
        .o_rr_avg_valid      (o_rr_avg_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int per, input int loc);
        i_rr_period         = 22'(per);
        i_rpeak_location    = 22'(loc);
        i_rr_period_updated = 1'b1;
        tick();
        i_rr_period_updated = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_alg_active = 1'b0;
        i_rec_ready = 1'b0;
        i_ce = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (o_rec_valid !== 1'b0 || o_fifo_level !== 4'd0 || o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: valid=%0b level=%0d ovf=%0b want 0/0/0", o_rec_valid, o_fifo_level, o_overflow);
        end
        total++;
        if (o_rec_data !== 45'd0 || o_rr_avg !== 22'd0 || o_rr_avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_data: data=%h avg=%0d avgv=%0b want 0", o_rec_data, o_rr_avg, o_rr_avg_valid);
        end
    endtask

    task automatic test_first_discard();
        i_alg_active = 1'b1;
        tick();
        strobe(200, 1000);
        total++;
        if (o_rec_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_discard: valid=%0b want 0", o_rec_valid);
        end
        repeat (3) tick();
        strobe(200, 1200);
        exp = '{artefact: 1'b0, rr_period: 22'd200, rpeak_location: 22'd1200};
        total++;
        if (o_rec_valid !== 1'b1 || o_fifo_level !== 4'd1 || o_rec_data !== exp) begin
            bad++;
            $display("FAIL first_record: valid=%0b level=%0d data=%h want 1/1/%h", o_rec_valid, o_fifo_level, o_rec_data, exp);
        end
        tick();
        total++;
        if (o_rec_data !== exp) begin
            bad++;
            $display("FAIL hold_stable: data=%h want %h", o_rec_data, exp);
        end
        i_rec_ready = 1'b1;
        tick();
        i_rec_ready = 1'b0;
        total++;
        if (o_fifo_level !== 4'd0 || o_rec_valid !== 1'b0) begin
            bad++;
            $display("FAIL pop_one: level=%0d valid=%0b want 0/0", o_fifo_level, o_rec_valid);
        end
    endtask

    task automatic test_artefact();
        int per [4] = '{49, 50, 500, 501};
        logic art [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) strobe(per[i], 10 + i);
        total++;
        if (o_fifo_level !== 4'd4) begin
            bad++;
            $display("FAIL artefact_level: level=%0d want 4", o_fifo_level);
        end
        i_rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = '{artefact: art[i], rr_period: 22'(per[i]), rpeak_location: 22'(10 + i)};
            total++;
            if (o_rec_data !== exp) begin
                bad++;
                $display("FAIL artefact_%0d: data=%h want %h", per[i], o_rec_data, exp);
            end
            tick();
        end
        i_rec_ready = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) strobe(100 + i, i);
        total++;
        if (o_fifo_level !== 4'd8 || o_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow: level=%0d ovf=%0b want 8/1", o_fifo_level, o_overflow);
        end
        i_rec_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp = '{artefact: 1'b0, rr_period: 22'(100 + i), rpeak_location: 22'(i)};
            total++;
            if (o_rec_data !== exp) begin
                bad++;
                $display("FAIL overflow_drain_%0d: data=%h want %h", i, o_rec_data, exp);
            end
            tick();
        end
        i_rec_ready = 1'b0;
        total++;
        if (o_fifo_level !== 4'd0 || o_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_after_drain: level=%0d ovf=%0b want 0/1", o_fifo_level, o_overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        i_alg_active = 1'b1;
        strobe(300, 0);
        for (int i = 1; i <= 8; i++) strobe(300, i);
        i_rec_ready = 1'b1;
        strobe(300, 9);
        i_rec_ready = 1'b0;
        total++;
        if (o_fifo_level !== 4'd8 || o_overflow !== 1'b0) begin
            bad++;
            $display("FAIL full_push_pop: level=%0d ovf=%0b want 8/0", o_fifo_level, o_overflow);
        end
        i_rec_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            exp = '{artefact: 1'b0, rr_period: 22'd300, rpeak_location: 22'(i)};
            total++;
            if (o_rec_data !== exp) begin
                bad++;
                $display("FAIL full_drain_%0d: data=%h want %h", i, o_rec_data, exp);
            end
            tick();
        end
        i_rec_ready = 1'b0;
    endtask

    task automatic test_deactivate();
        for (int i = 31; i <= 33; i++) strobe(120, i);
        i_alg_active = 1'b0;
        tick();
        strobe(120, 34);
        total++;
        if (o_fifo_level !== 4'd3) begin
            bad++;
            $display("FAIL inactive_no_push: level=%0d want 3", o_fifo_level);
        end
        i_alg_active = 1'b1;
        strobe(120, 35);
        total++;
        if (o_fifo_level !== 4'd3) begin
            bad++;
            $display("FAIL rearm_discard: level=%0d want 3", o_fifo_level);
        end
        strobe(120, 36);
        i_rec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = '{artefact: 1'b0, rr_period: 22'd120, rpeak_location: 22'((i == 3) ? 36 : 31 + i)};
            total++;
            if (o_rec_data !== exp || o_rec_valid !== 1'b1) begin
                bad++;
                $display("FAIL deact_drain_%0d: data=%h valid=%0b want %h/1", i, o_rec_data, o_rec_valid, exp);
            end
            tick();
        end
        i_rec_ready = 1'b0;
    endtask

    task automatic test_ce();
        strobe(150, 40);
        i_ce = 1'b0;
        i_rec_ready = 1'b1;
        strobe(150, 41);
        i_rec_ready = 1'b0;
        total++;
        if (o_fifo_level !== 4'd0) begin
            bad++;
            $display("FAIL ce_gate: level=%0d want 0", o_fifo_level);
        end
        i_ce = 1'b1;
        strobe(150, 42);
        exp = '{artefact: 1'b0, rr_period: 22'd150, rpeak_location: 22'd42};
        total++;
        if (o_fifo_level !== 4'd1 || o_rec_data !== exp) begin
            bad++;
            $display("FAIL ce_resume: level=%0d data=%h want 1/%h", o_fifo_level, o_rec_data, exp);
        end
    endtask

    task automatic test_average();
        do_reset();
        i_alg_active = 1'b1;
        i_rec_ready = 1'b1;
        strobe(240, 0);
        for (int i = 1; i <= 7; i++) strobe(240, i);
`ifdef RR_AVG_EN
        total++;
        if (o_rr_avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL avg_early: avgv=%0b want 0", o_rr_avg_valid);
        end
`endif
        strobe(240, 8);
`ifdef RR_AVG_EN
        total++;
        if (o_rr_avg !== 22'd240 || o_rr_avg_valid !== 1'b1) begin
            bad++;
            $display("FAIL avg_8: avg=%0d avgv=%0b want 240/1", o_rr_avg, o_rr_avg_valid);
        end
`endif
        strobe(400, 9);
        strobe(20, 10);
`ifdef RR_AVG_EN
        total++;
        if (o_rr_avg !== 22'd260 || o_rr_avg_valid !== 1'b1) begin
            bad++;
            $display("FAIL avg_9: avg=%0d avgv=%0b want 260/1", o_rr_avg, o_rr_avg_valid);
        end
`else
        total++;
        if (o_rr_avg !== 22'd0 || o_rr_avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL avg_disabled: avg=%0d avgv=%0b want 0/0", o_rr_avg, o_rr_avg_valid);
        end
`endif
        i_rec_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_discard();
        test_artefact();
        test_overflow();
        test_full_push_pop();
        test_deactivate();
        test_ce();
        test_average();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_record_buffer.md
Name: rr_record_buffer

Overview:
- Consumer for the R-peak detection core outputs `rr_period`, `rr_period_updated` and `rpeak_location`.
- Turns each RR update into a record with a range-check flag, queues it in a small FIFO and drains it over a valid/ready stream to the readout logic.
- Optionally maintains a running average of recent valid RR intervals.

Parameters:
- CTR_WIDTH, 22, width of sample counter, RR period and R-peak location.
- FIFO_DEPTH, 8, record slots; power of two, at least 2.
- RR_MIN, 50, smallest physiologically valid RR period in samples.
- RR_MAX, 500, largest physiologically valid RR period in samples.
- NAVG, 8, intervals averaged when RR_AVG_EN is defined; power of two.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_ce  in  1  clock enable for the capture side only.
- i_alg_active  in  1  detector running.
- i_rr_period  in  CTR_WIDTH  RR period in samples.
- i_rr_period_updated  in  1  one-cycle strobe: new period/location valid.
- i_rpeak_location  in  CTR_WIDTH  counter value at the R peak.
- o_rec_data  out  2*CTR_WIDTH+1  {artefact, rr_period, rpeak_location}.
- o_rec_valid  out  1  record available at head.
- i_rec_ready  in  1  sink accepts head.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- o_overflow  out  1  sticky: a record was dropped.
- o_rr_avg  out  CTR_WIDTH  running mean RR (RR_AVG_EN only).
- o_rr_avg_valid  out  1  mean valid (RR_AVG_EN only).

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - State goes to WAIT_FIRST.
  - FIFO is emptied. All outputs are 0, including o_rec_data, o_overflow and the average state.
- FSM states:
  - WAIT_FIRST → ARMED when i_ce && i_alg_active && i_rr_period_updated. This first strobe is discarded, because the first period has no preceding peak.
  - ARMED → WAIT_FIRST when i_alg_active=0 (sampled with i_ce). FIFO contents are kept and continue to drain.
- Capture:
  - A push occurs in ARMED when i_ce && i_rr_period_updated.
  - artefact = (i_rr_period < RR_MIN) || (i_rr_period > RR_MAX). Compare unsigned; the bounds are inclusive-valid.
- FIFO:
  - First-word-fall-through with registered pointers and storage.
  - o_rec_valid = level != 0.
  - A pushed record appears at o_rec_data/o_rec_valid one cycle after the capture edge.
  - A pop occurs when o_rec_valid && i_rec_ready. The handshake is not gated by i_ce.
  - o_rec_data holds stable while o_rec_valid && !i_rec_ready.
- Boundaries:
  - Push while full with no pop: the record is dropped, o_overflow sets and stays set until reset, and the level stays at FIFO_DEPTH.
  - Push and pop in the same cycle while full: both succeed and the level is unchanged.
  - Push and pop in the same cycle while empty: no pop occurs (valid was 0); the level goes to 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - i_ce=0: no push occurs and the FSM holds, but pops still proceed.

Optional Feature:
- Macro RR_AVG_EN.
- Defined:
  - Non-artefact pushes, including ones dropped on overflow, enter an NAVG-entry circular history.
  - A running sum of width CTR_WIDTH+$clog2(NAVG) is maintained by adding the new value and subtracting the oldest.
  - o_rr_avg = sum >> $clog2(NAVG), registered, updated one cycle after the push.
  - o_rr_avg_valid rises after NAVG entries and stays high until reset.
- Not defined: o_rr_avg and o_rr_avg_valid are tied to 0 and no history storage is built.

Decomposition:
- Shared package rr_pkg holds:
  - rr_record_t packed struct {artefact, rr_period, rpeak_location};
  - the typedef rr_state_e {WAIT_FIRST, ARMED};
  - RR_MIN/RR_MAX defaults.
- One sub-module: sync_fifo (parameterised width and depth, FWFT, full/empty/level).

Test Plan:
- Reset, then alg_active=1 and strobes with period 200 at t0 and t0+200 → the first is discarded; one record {0,200,loc} appears with valid 1 cycle after the second strobe, and level=1.
- Periods 49, 50, 500, 501 → artefact flags 1, 0, 0, 1 in order.
- ready=0 and 9 strobes with FIFO_DEPTH=8 → level=8, o_overflow=1, the 9th record lost; draining returns records 1–8 in order.
- FIFO full with ready=1 and a strobe in the same cycle → level stays 8, o_overflow stays 0, the new record lands at the tail.
- alg_active drops with 3 records queued → FSM returns to WAIT_FIRST and the 3 records still drain; the next strobe after re-activation is discarded.
- RR_AVG_EN with 8 periods of 240, then one of 400 → avg=240 with valid after the 8th; after the 9th, avg = (7*240+400)/8 = 260.
